// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// FSM state encoding and the default synchroniser depth live here.
package clk_period_meter_pkg;

    // state      | meaning
    // ST_IDLE    | after reset, waiting for the first rising edge
    // ST_ARMED   | first edge seen, no period measured yet
    // ST_MEASURE | periods being reported on every rising edge
    // ST_NO_SIG  | no rising edge for TIMEOUT_CYC cycles
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_NO_SIG  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_period_meter_sig_sync_edge.sv
// Synchronises the measured signal into I_CLK and produces single-cycle
// rise/fall pulses from one extra edge register.
module clk_period_meter_sig_sync_edge
    import clk_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic I_CLK,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise_det,
    output logic fall_det
);

    // SYNC_STAGES must be at least 2 for metastability settling
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            edge_q <= sync_out;
        end
    end

    assign rise_det = sync_out & ~edge_q;
    assign fall_det = ~sync_out & edge_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in I_CLK cycles,
// with lock detection and a loss-of-signal timeout.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             I_CLK,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             rise_det;
    logic             fall_det;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev_period;
    logic             cnt_at_to;

    state_t state, state_next;
    logic   load_high;
    logic   load_period;
    logic   upd_lock;
    logic   go_nosig;
    logic   clr_timeout;

    clk_period_meter_sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .I_CLK   (I_CLK),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .rise_det(rise_det),
        .fall_det(fall_det)
    );

    // Loading 1 on rise makes cnt at the next rise equal the period.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise_det) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cnt_at_to = (cnt == TO_VAL);

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rise in the terminal cycle takes priority over the timeout.
    always_comb begin
        state_next  = state;
        load_high   = 1'b0;
        load_period = 1'b0;
        upd_lock    = 1'b0;
        go_nosig    = 1'b0;
        clr_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_det) begin
                    state_next = ST_ARMED;
                end else if (cnt_at_to) begin
                    state_next = ST_NO_SIG;
                    go_nosig   = 1'b1;
                end
            end
            ST_ARMED: begin
                load_high = fall_det;
                if (rise_det) begin
                    load_period = 1'b1;
                    state_next  = ST_MEASURE;
                end else if (cnt_at_to) begin
                    state_next = ST_NO_SIG;
                    go_nosig   = 1'b1;
                end
            end
            ST_MEASURE: begin
                load_high = fall_det;
                if (rise_det) begin
                    load_period = 1'b1;
                    upd_lock    = 1'b1;
                end else if (cnt_at_to) begin
                    state_next = ST_NO_SIG;
                    go_nosig   = 1'b1;
                end
            end
            ST_NO_SIG: begin
                if (rise_det) begin
                    state_next  = ST_ARMED;
                    clr_timeout = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // First measurement after arming never locks, whatever prev_period holds.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            period      <= '0;
            high_time   <= '0;
            prev_period <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= load_period;
            if (load_high) begin
                high_time <= cnt;
            end
            if (load_period) begin
                period      <= cnt;
                prev_period <= cnt;
                locked      <= upd_lock && (cnt == prev_period);
            end
            if (go_nosig) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
            end else if (clr_timeout) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: timeout, period/high-time, lock,
// reset recovery and stuck-signal behaviour with hand-computed values.
module tb_clk_period_meter;

    logic        I_CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] q_per[$];
    logic [31:0] q_high[$];
    logic [31:0] q_lock[$];

    clk_period_meter #(
        .CNT_W      (32),
        .TIMEOUT_CYC(1000),
        .SYNC_STAGES(2)
    ) dut (
        .I_CLK     (I_CLK),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 I_CLK = ~I_CLK;

    always @(negedge I_CLK) begin
        if (meas_valid) begin
            q_per.push_back(period);
            q_high.push_back(high_time);
            q_lock.push_back({31'd0, locked});
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_strobe(input string tag, input int idx,
                              input logic [31:0] p, input logic [31:0] h, input logic l);
        chk_eq({tag, "_period"}, (idx < q_per.size()) ? q_per[idx] : 32'hFFFF_FFFF, p);
        chk_eq({tag, "_high"},   (idx < q_high.size()) ? q_high[idx] : 32'hFFFF_FFFF, h);
        chk_eq({tag, "_locked"}, (idx < q_lock.size()) ? q_lock[idx] : 32'hFFFF_FFFF, {31'd0, l});
    endtask

    task automatic clear_q();
        q_per.delete();
        q_high.delete();
        q_lock.delete();
    endtask

    task automatic gen(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge I_CLK);
            sig_in = 1'b0;
            repeat (lo) @(negedge I_CLK);
        end
    endtask

    initial begin
        repeat (3) @(negedge I_CLK);
        chk_eq("rst_period",  period, 0);
        chk_eq("rst_high",    high_time, 0);
        chk_eq("rst_valid",   {31'd0, meas_valid}, 0);
        chk_eq("rst_locked",  {31'd0, locked}, 0);
        chk_eq("rst_timeout", {31'd0, timeout}, 0);
        rst_n = 1'b1;

        // sig held low: timeout asserts exactly after edge 1001
        repeat (1000) @(negedge I_CLK);
        chk_eq("to_before", {31'd0, timeout}, 0);
        @(negedge I_CLK);
        chk_eq("to_after", {31'd0, timeout}, 1);

        gen(5, 5, 1);
        chk_eq("to_clear", {31'd0, timeout}, 0);
        chk_eq("to_no_strobe", q_per.size(), 0);

        gen(5, 5, 2);
        chk_eq("x10_count", q_per.size(), 2);
        chk_strobe("x10_s1", 0, 10, 5, 1'b0);
        chk_strobe("x10_s2", 1, 10, 5, 1'b1);
        clear_q();

        gen(10, 10, 3);
        chk_eq("x20_count", q_per.size(), 3);
        chk_strobe("x20_s1", 0, 10, 5, 1'b1);
        chk_strobe("x20_s2", 1, 20, 10, 1'b0);
        chk_strobe("x20_s3", 2, 20, 10, 1'b1);
        clear_q();

        // stuck high after lock
        sig_in = 1'b1;
        repeat (1002) @(negedge I_CLK);
        chk_eq("stuck_to_before", {31'd0, timeout}, 0);
        chk_eq("stuck_lock_before", {31'd0, locked}, 1);
        @(negedge I_CLK);
        chk_eq("stuck_timeout", {31'd0, timeout}, 1);
        chk_eq("stuck_locked", {31'd0, locked}, 0);
        chk_eq("stuck_period", period, 20);
        chk_eq("stuck_high", high_time, 10);
        chk_eq("stuck_count", q_per.size(), 1);
        chk_strobe("stuck_s1", 0, 20, 10, 1'b1);
        clear_q();

        sig_in = 1'b0;
        repeat (7) @(negedge I_CLK);
        chk_eq("fall_nosig_high", high_time, 10);
        gen(1, 7, 4);
        chk_eq("pulse_timeout", {31'd0, timeout}, 0);
        chk_eq("pulse_count", q_per.size(), 3);
        chk_strobe("pulse_s1", 0, 8, 1, 1'b0);
        chk_strobe("pulse_s2", 1, 8, 1, 1'b1);
        chk_strobe("pulse_s3", 2, 8, 1, 1'b1);
        clear_q();

        // async reset mid-period while locked
        chk_eq("pre_rst_locked", {31'd0, locked}, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("arst_period",  period, 0);
        chk_eq("arst_high",    high_time, 0);
        chk_eq("arst_valid",   {31'd0, meas_valid}, 0);
        chk_eq("arst_locked",  {31'd0, locked}, 0);
        chk_eq("arst_timeout", {31'd0, timeout}, 0);
        repeat (3) @(negedge I_CLK);
        rst_n = 1'b1;
        clear_q();

        gen(1, 7, 1);
        chk_eq("rearm_no_strobe", q_per.size(), 0);
        gen(1, 7, 2);
        chk_eq("rearm_count", q_per.size(), 2);
        chk_strobe("rearm_s1", 0, 8, 1, 1'b0);
        chk_strobe("rearm_s2", 1, 8, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
